// File: rtl/mio_bus_responder.sv
// Memory/IO bus responder for the CPU data port: RAM, LED and switch decode with wait states.
// Optional feature: define MIO_COUNTER_EN to build the free-running cycle counter at 0xF000_0004.
module mio_bus_responder #(
  parameter int RAM_AW      = 10,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        CPU_MIO,
  input  logic        mem_ifWriteMem,
  input  logic [31:0] Address_out,
  input  logic [31:0] Data_out,
  output logic [31:0] Data_in,
  output logic        MIO_ready,
  input  logic [15:0] sw_in,
  output logic [15:0] led_out,
  output logic        bus_error
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  typedef enum logic [2:0] {DEC_RAM, DEC_LED, DEC_SW, DEC_CNT, DEC_NONE} dec_t;

  function automatic dec_t decode(input logic [31:0] a);
    dec_t d;
    d = DEC_NONE;
    if (a[31:28] == 4'h0)
      d = DEC_RAM;
    else if (a[31:2] == 30'h3800_0000)
      d = DEC_LED;
    else if (a[31:2] == 30'h3C00_0000)
      d = DEC_SW;
    else if (a[31:2] == 30'h3C00_0001)
      d = DEC_CNT;
    return d;
  endfunction

  state_t              state;
  logic [3:0]          wait_cnt;

  dec_t                dec_p0;
  logic [RAM_AW-1:0]   idx_p0;
  logic [31:0]         wdata_p0;
  logic                we_p0;

  logic [31:0]         ram [2**RAM_AW];
  logic [31:0]         ram_rdata;
  logic [15:0]         sw_s1;
  logic [15:0]         sw_s2;
  logic [31:0]         cnt_rd;
  logic [31:0]         rd_mux;
  logic                capture;
  logic                resp_write;

  assign capture    = (state == IDLE) && CPU_MIO;
  assign resp_write = (state == RESP) && we_p0 && !rst;

  // Request capture: only these copies feed the response, so the CPU may change its inputs freely.
  always_ff @(posedge clk) begin
    if (capture) begin
      dec_p0   <= decode(Address_out);
      idx_p0   <= Address_out[RAM_AW+1:2];
      wdata_p0 <= Data_out;
      we_p0    <= mem_ifWriteMem;
    end
  end

  // RAM is read at capture time so the word is ready by RESP even with zero wait states.
  always_ff @(posedge clk) begin
    if (capture)
      ram_rdata <= ram[Address_out[RAM_AW+1:2]];
    if (resp_write && dec_p0 == DEC_RAM)
      ram[idx_p0] <= wdata_p0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sw_s1 <= '0;
      sw_s2 <= '0;
    end else begin
      sw_s1 <= sw_in;
      sw_s2 <= sw_s1;
    end
  end

`ifdef MIO_COUNTER_EN
  logic [31:0] cyc_cnt;

  always_ff @(posedge clk) begin
    if (rst)
      cyc_cnt <= '0;
    else if (resp_write && dec_p0 == DEC_CNT)
      cyc_cnt <= '0;
    else
      cyc_cnt <= cyc_cnt + 32'd1;
  end

  assign cnt_rd = cyc_cnt;
`else
  assign cnt_rd = '0;
`endif

  always_comb begin
    rd_mux = 32'hDEAD_BEEF;
    case (dec_p0)
      DEC_RAM: rd_mux = ram_rdata;
      DEC_LED: rd_mux = {16'h0000, led_out};
      DEC_SW:  rd_mux = {16'h0000, sw_s2};
      DEC_CNT: rd_mux = cnt_rd;
      default: rd_mux = 32'hDEAD_BEEF;
    endcase
  end

  // Control FSM; outputs are registered and updated in the RESP cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      MIO_ready <= 1'b0;
      Data_in   <= '0;
      led_out   <= '0;
      bus_error <= 1'b0;
    end else begin
      MIO_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (CPU_MIO) begin
            if (WAIT_CYCLES == 0) begin
              state <= RESP;
            end else begin
              state    <= WAIT;
              wait_cnt <= 4'(WAIT_CYCLES);
            end
          end
        end
        WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt <= 4'd1)
            state <= RESP;
        end
        RESP: begin
          MIO_ready <= 1'b1;
          state     <= IDLE;
          if (dec_p0 == DEC_NONE)
            bus_error <= 1'b1;
          if (we_p0) begin
            if (dec_p0 == DEC_LED)
              led_out <= wdata_p0[15:0];
          end else begin
            Data_in <= rd_mux;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mio_bus_responder.sv
// Self-checking bench: three responders (0, 1 and 3 wait states) against a transaction-level model.
module tb_mio_bus_responder;

`ifdef MIO_COUNTER_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  mio;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [15:0] sw;
  logic [31:0] din [3];
  logic [2:0]  rdy;
  logic [2:0]  err;
  logic [15:0] led [3];

  always #5 clk = ~clk;

  mio_bus_responder #(.RAM_AW(10), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst(rst), .CPU_MIO(mio[0]), .mem_ifWriteMem(we), .Address_out(addr),
    .Data_out(wdata), .Data_in(din[0]), .MIO_ready(rdy[0]), .sw_in(sw), .led_out(led[0]),
    .bus_error(err[0]));
  mio_bus_responder #(.RAM_AW(10), .WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .rst(rst), .CPU_MIO(mio[1]), .mem_ifWriteMem(we), .Address_out(addr),
    .Data_out(wdata), .Data_in(din[1]), .MIO_ready(rdy[1]), .sw_in(sw), .led_out(led[1]),
    .bus_error(err[1]));
  mio_bus_responder #(.RAM_AW(10), .WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .rst(rst), .CPU_MIO(mio[2]), .mem_ifWriteMem(we), .Address_out(addr),
    .Data_out(wdata), .Data_in(din[2]), .MIO_ready(rdy[2]), .sw_in(sw), .led_out(led[2]),
    .bus_error(err[2]));

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] m_ram [3][1024];
  bit          m_val [3][1024];
  logic [15:0] m_led [3];
  bit          m_err [3];
  logic [31:0] m_din [3];
  bit          m_din_ok [3];

  function automatic int wc(input int i);
    return (i == 0) ? 0 : (i == 1) ? 1 : 3;
  endfunction

  // 0 RAM, 1 LED, 2 switches, 3 counter, 4 unmapped
  function automatic int kind(input logic [31:0] a);
    if (a[31:28] == 4'h0) return 0;
    if ({a[31:2], 2'b00} == 32'hE000_0000) return 1;
    if ({a[31:2], 2'b00} == 32'hF000_0000) return 2;
    if ({a[31:2], 2'b00} == 32'hF000_0004) return 3;
    return 4;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_led[i] = '0; m_err[i] = 1'b0; m_din[i] = '0; m_din_ok[i] = 1'b1;
    end
  endtask

  task automatic cycles(input int n);
    for (int k = 0; k < n; k++) begin @(posedge clk); #1; end
  endtask

  task automatic txn(input int i, input bit w, input logic [31:0] a, input logic [31:0] d,
                     input bit hold, output logic [31:0] got);
    int k;
    bit seen;
    int kd;
    logic [31:0] exp;
    kd = kind(a);
    case (kd)
      0:       exp = m_ram[i][a[11:2]];
      1:       exp = {16'h0, m_led[i]};
      2:       exp = {16'h0, sw};
      3:       exp = 32'h0;
      default: exp = 32'hDEAD_BEEF;
    endcase
    we = w; addr = a; wdata = d; mio[i] = 1'b1;
    @(posedge clk); #1;
    if (!hold) mio[i] = 1'b0;
    we = 1'($urandom); addr = $urandom; wdata = $urandom;
    seen = 1'b0; k = 0;
    while (!seen && k < 20) begin
      @(posedge clk); #1;
      k++;
      if (rdy[i]) seen = 1'b1;
    end
    mio[i] = 1'b0;
    if (w) begin
      if (kd == 0) begin m_ram[i][a[11:2]] = d; m_val[i][a[11:2]] = 1'b1; end
      if (kd == 1) m_led[i] = d[15:0];
      if (kd == 4) m_err[i] = 1'b1;
    end else begin
      if (kd == 4) m_err[i] = 1'b1;
      m_din[i]    = exp;
      m_din_ok[i] = !(kd == 3 && CNT_EN) && !(kd == 0 && !m_val[i][a[11:2]]);
    end
    got = din[i];
    n_checks++;
    if (!seen || k != wc(i) + 1) begin
      n_errors++;
      $display("FAIL latency inst%0d addr=%h: got %0d cycles (seen=%0d), expected %0d", i, a, k, seen, wc(i) + 1);
    end
    if (m_din_ok[i]) begin
      n_checks++;
      if (din[i] !== m_din[i]) begin
        n_errors++;
        $display("FAIL data_in inst%0d addr=%h we=%0d: got %h expected %h", i, a, w, din[i], m_din[i]);
      end
    end
    @(posedge clk); #1;
    n_checks++;
    if (rdy[i] !== 1'b0 || led[i] !== m_led[i] || err[i] !== m_err[i]) begin
      n_errors++;
      $display("FAIL post inst%0d addr=%h: rdy=%b led=%h err=%b expected rdy=0 led=%h err=%b",
               i, a, rdy[i], led[i], err[i], m_led[i], m_err[i]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; mio = '0; we = 1'b0; addr = '0; wdata = '0; sw = '0;
    cycles(3);
    rst = 1'b0;
    model_reset();
    cycles(1);
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (rdy[i] !== 1'b0 || din[i] !== 32'h0 || led[i] !== 16'h0 || err[i] !== 1'b0) begin
        n_errors++;
        $display("FAIL reset inst%0d: rdy=%b din=%h led=%h err=%b expected all zero", i, rdy[i], din[i], led[i], err[i]);
      end
    end
  endtask

  task automatic test_ram_basic();
    logic [31:0] g;
    txn(1, 1'b1, 32'h0000_0010, 32'h1234_5678, 1'b0, g);
    txn(1, 1'b0, 32'h0000_0010, 32'h0, 1'b0, g);
    n_checks++;
    if (g !== 32'h1234_5678) begin
      n_errors++;
      $display("FAIL ram_basic: got %h expected 12345678", g);
    end
  endtask

  task automatic test_wait_states();
    logic [31:0] g;
    for (int j = 0; j < 3; j += 2) begin
      txn(j, 1'b1, 32'h0000_0044, 32'hA0B0_C0D0 + j, 1'b1, g);
      txn(j, 1'b0, 32'h0000_0044, 32'h0, 1'b1, g);
      for (int k = 0; k < 6; k++) begin
        @(posedge clk); #1;
        n_checks++;
        if (rdy[j] !== 1'b0) begin
          n_errors++;
          $display("FAIL extra_ready inst%0d cycle %0d: got %b expected 0", j, k, rdy[j]);
        end
      end
    end
  endtask

  task automatic test_led_sw();
    logic [31:0] g;
    txn(1, 1'b1, 32'hE000_0000, 32'hFFFF_A5A5, 1'b0, g);
    n_checks++;
    if (led[1] !== 16'hA5A5) begin
      n_errors++;
      $display("FAIL led_write: got %h expected a5a5", led[1]);
    end
    txn(1, 1'b0, 32'hE000_0000, 32'h0, 1'b0, g);
    sw = 16'h00F0;
    cycles(2);
    txn(1, 1'b0, 32'hF000_0000, 32'h0, 1'b0, g);
    n_checks++;
    if (g !== 32'h0000_00F0) begin
      n_errors++;
      $display("FAIL sw_read: got %h expected 000000f0", g);
    end
  endtask

  task automatic test_counter();
    logic [31:0] g;
    txn(1, 1'b1, 32'hF000_0004, 32'h1234_0000, 1'b0, g);
    cycles(10);
    txn(1, 1'b0, 32'hF000_0004, 32'h0, 1'b0, g);
`ifdef MIO_COUNTER_EN
    n_checks++;
    if (g < 32'd11 || g > 32'd20) begin
      n_errors++;
      $display("FAIL counter: got %0d expected between 11 and 20", g);
    end
`else
    n_checks++;
    if (g !== 32'h0 || err[1] !== 1'b0) begin
      n_errors++;
      $display("FAIL counter_off: got %h err=%b expected 0 and err=0", g, err[1]);
    end
`endif
  endtask

  task automatic test_bus_error();
    logic [31:0] g;
    txn(1, 1'b0, 32'h4000_0000, 32'h0, 1'b0, g);
    n_checks++;
    if (g !== 32'hDEAD_BEEF || err[1] !== 1'b1) begin
      n_errors++;
      $display("FAIL bus_error: got %h err=%b expected deadbeef err=1", g, err[1]);
    end
    txn(1, 1'b1, 32'h0000_0010, 32'h5555_AAAA, 1'b0, g);
    txn(1, 1'b0, 32'h0000_0010, 32'h0, 1'b0, g);
  endtask

  task automatic test_reset_abort();
    logic [31:0] g;
    txn(2, 1'b1, 32'h0000_0020, 32'h1111_2222, 1'b0, g);
    txn(2, 1'b1, 32'hE000_0000, 32'h0000_3C3C, 1'b0, g);
    we = 1'b1; addr = 32'h0000_0020; wdata = 32'hCAFE_0000; mio[2] = 1'b1;
    @(posedge clk); #1;
    mio[2] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    for (int k = 0; k < 6; k++) begin
      n_checks++;
      if (rdy[2] !== 1'b0 || led[2] !== 16'h0) begin
        n_errors++;
        $display("FAIL abort cycle %0d: rdy=%b led=%h expected 0 and 0000", k, rdy[2], led[2]);
      end
      @(posedge clk); #1;
    end
    txn(2, 1'b0, 32'h0000_0020, 32'h0, 1'b0, g);
    n_checks++;
    if (g !== 32'h1111_2222) begin
      n_errors++;
      $display("FAIL abort_ram: got %h expected 11112222", g);
    end
  endtask

  task automatic test_random();
    logic [31:0] g;
    logic [31:0] a;
    bit w;
    int i;
    for (int n = 0; n < 60; n++) begin
      i = $urandom_range(0, 2);
      w = 1'($urandom);
      case ($urandom_range(0, 5))
        0, 1:    a = {4'h0, 16'($urandom), 7'd0, 3'($urandom_range(0, 7)), 2'($urandom)};
        2:       a = {30'h3800_0000, 2'($urandom)};
        3:       a = {30'h3C00_0000, 2'($urandom)};
        4:       a = {30'h3C00_0001, 2'($urandom)};
        default: a = {4'($urandom_range(1, 13)), 28'($urandom)};
      endcase
      if (kind(a) == 0 && !m_val[i][a[11:2]]) w = 1'b1;
      if (kind(a) == 3 && CNT_EN) w = 1'b1;
      sw = 16'($urandom);
      cycles(2);
      txn(i, w, a, $urandom, 1'($urandom), g);
    end
  endtask

  initial begin
    test_reset();
    test_ram_basic();
    test_wait_states();
    test_led_sw();
    test_counter();
    test_bus_error();
    test_reset_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mio_bus_responder.md
# mio_bus_responder

Memory/IO bus responder that services the pipelined CPU's data-memory port. Accepts a CPU request (CPU_MIO strobe, address, write data, write enable), decodes the address to internal data RAM or memory-mapped peripherals, inserts programmable wait states and returns read data with a one-cycle MIO_ready pulse. Sits between the CPU core and the board-level RAM/LED/switch fabric.

## Interface
- RAM_AW, default 10: RAM word-address width; RAM holds 2^RAM_AW 32-bit words.
- WAIT_CYCLES, default 1: wait states inserted between request capture and MIO_ready (0–15).
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- CPU_MIO  in  1  request strobe from CPU; sampled only in IDLE.
- mem_ifWriteMem  in  1  1 = write, 0 = read; sampled with CPU_MIO.
- Address_out  in  32  byte address from CPU; bits [1:0] ignored.
- Data_out  in  32  write data from CPU.
- Data_in  out  32  registered read data to CPU; valid while MIO_ready=1.
- MIO_ready  out  1  one-cycle completion pulse for reads and writes.
- sw_in  in  16  board switches, synchronised internally (2 flops).
- led_out  out  16  LED register.
- bus_error  out  1  sticky flag: access to unmapped address.

## Operation
- Address map (on Address_out[31:28], then low bits):
  - 0x0xxx_xxxx: RAM, word index Address_out[RAM_AW+1:2]; higher bits aliased.
  - 0xE000_0000: LED register; write stores Data_out[15:0]; read returns {16'b0, led_out}.
  - 0xF000_0000: switches; read returns {16'b0, synchronised sw_in}; writes ignored, no error.
  - 0xF000_0004: cycle counter (see Configuration).
  - anything else: unmapped; read returns 0xDEAD_BEEF, write dropped, bus_error set.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: if CPU_MIO=1 capture address, data, write enable; go WAIT if WAIT_CYCLES>0, else RESP. Wait counter loaded with WAIT_CYCLES.
  - WAIT: decrement counter; at 1 go RESP. CPU_MIO ignored.
  - RESP: perform write (RAM/LED) or load Data_in with read result; MIO_ready=1; go IDLE.
- Only captured values used; CPU changing inputs mid-transaction has no effect.
- Data_in holds last read value until next read response; write responses leave Data_in unchanged.
- RAM is a synchronous single-port array; contents not reset.
- bus_error clears only on rst.

## Timing
- Request sampled at edge N (IDLE, CPU_MIO=1) -> MIO_ready high in cycle N+1+WAIT_CYCLES, for exactly one cycle.
- Earliest next capture: the edge after the RESP cycle (one IDLE cycle between transactions minimum); back-to-back throughput one access per WAIT_CYCLES+2 cycles.
- Write side effects (RAM, led_out) visible from the cycle after MIO_ready.
- Reset values: state IDLE, MIO_ready 0, Data_in 0, led_out 0, bus_error 0, counter 0, wait counter 0, switch synchroniser 0.
- rst mid-transaction: transaction aborted, no write committed, no MIO_ready pulse; back to IDLE next cycle.
- Read of 0xF000_0000 returns sw_in value from 2 cycles before RESP (synchroniser latency).

## Configuration
- MIO_COUNTER_EN defined: 32-bit free-running counter increments every cycle after reset, wraps 0xFFFF_FFFF->0; read at 0xF000_0004 returns value latched in RESP cycle; writes clear it to 0.
- Undefined: no counter logic; 0xF000_0004 reads 0, writes ignored; address still mapped (no bus_error).

## Test plan
- Reset then RAM write 0x0000_0010 <= 0x1234_5678, read back -> MIO_ready exactly 2 cycles after each request (WAIT_CYCLES=1), Data_in=0x1234_5678.
- WAIT_CYCLES=0 and 3: read request at edge N -> MIO_ready at N+1 and N+4 respectively; CPU_MIO held high during WAIT causes no extra transaction.
- Write 0xE000_0000 <= 0xFFFF_A5A5 -> led_out=0xA5A5; read back -> 0x0000_A5A5; sw_in=0x00F0 read at 0xF000_0000 -> 0x0000_00F0.
- Read 0x4000_0000 -> Data_in=0xDEAD_BEEF, bus_error=1 and remains 1 after further valid accesses until rst.
- rst asserted during WAIT of write to 0x0000_0020 <= 0xCAFE_0000 -> no MIO_ready, RAM word unchanged, led_out 0.
- MIO_COUNTER_EN: write 0xF000_0004 then read after 10 idle cycles -> small nonzero value consistent with elapsed cycles; undefined build -> reads 0, bus_error stays 0.
